wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 149 ++++++++++++++
 tb/tb_wb_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - register-file writeback stage with load data extension
// Selects ALU/PC+4/imm/load data, waits on memory for loads, and counts retired writes.
module wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_sel,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wr,
    input  logic [2:0]            in_funct3,
    input  logic [1:0]            in_boff,
    input  logic [XLEN-1:0]       in_rout,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [XLEN-1:0]       in_imm,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  busy,
    output logic                  load_err,
    output logic [CNT_W-1:0]      retire_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

    state_t                  state_q, state_d;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic [XLEN-1:0]         data_q, data_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              boff_q, boff_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    accept;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [XLEN-1:0]         ld_data;
    logic                    ld_bad;
    logic [XLEN-1:0]         src_data;

    assign in_ready   = enable && (state_q != WAIT_MEM);
    assign accept     = in_valid && in_ready;
    assign busy       = (state_q != IDLE);
    assign rf_we      = (state_q == WRITE) && wr_q && (rd_q != '0) && !err_q;
    assign load_err   = (state_q == WRITE) && err_q;
    assign rf_waddr   = rd_q;
    assign rf_wdata   = data_q;
    assign retire_cnt = cnt_q;

    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (boff_q)
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            2'd3:    ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        // Halfword position comes from boff[1] alone; misaligned halfword offsets round down.
        ld_half = boff_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_bad  = 1'b0;
        case (funct3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            3'b010:  ld_data = mem_rdata;
            default: begin
                ld_data = '0;
                ld_bad  = 1'b1;
            end
        endcase
    end

    always_comb begin
        case (in_sel)
            2'd1:    src_data = in_pc + {{(XLEN-3){1'b0}}, 3'b100};
            2'd2:    src_data = in_imm;
            default: src_data = in_rout;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        data_d   = data_q;
        funct3_d = funct3_q;
        boff_d   = boff_q;
        err_d    = err_q;
        cnt_d    = rf_we ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
        case (state_q)
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    data_d  = ld_data;
                    err_d   = ld_bad;
                    state_d = WRITE;
                end
            end
            default: begin
                if (accept) begin
                    rd_d  = in_rd;
                    wr_d  = in_wr;
                    err_d = 1'b0;
                    if (in_sel == 2'd3) begin
                        funct3_d = in_funct3;
                        boff_d   = in_boff;
                        state_d  = WAIT_MEM;
                    end else begin
                        data_d  = src_data;
                        state_d = WRITE;
                    end
                end else if (state_q == WRITE) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_q     <= '0;
            wr_q     <= 1'b0;
            data_q   <= '0;
            funct3_q <= '0;
            boff_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            data_q   <= data_d;
            funct3_q <= funct3_d;
            boff_q   <= boff_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
// Vector table plus scoreboard of expected register writes; a CNT_W=2 copy checks counter wrap.
module tb_wb_stage;

    logic        clk, reset, enable, in_valid, in_wr, mem_rvalid;
    logic [1:0]  in_sel, in_boff;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [31:0] in_rout, in_pc, in_imm, mem_rdata;

    logic        in_ready, rf_we, busy, load_err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] retire_cnt;

    logic        in_ready_s, rf_we_s, busy_s, load_err_s;
    logic [4:0]  rf_waddr_s;
    logic [31:0] rf_wdata_s;
    logic [1:0]  retire_cnt_s;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        wr;
        logic [2:0]  f3;
        logic [1:0]  boff;
        logic [31:0] a;
        logic [31:0] mdata;
        int          waitc;
        logic        exp_we;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic        err;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];

    wb_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_rd(in_rd), .in_wr(in_wr), .in_funct3(in_funct3), .in_boff(in_boff),
        .in_rout(in_rout), .in_pc(in_pc), .in_imm(in_imm), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .load_err(load_err), .retire_cnt(retire_cnt)
    );

    wb_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_sel(in_sel), .in_rd(in_rd), .in_wr(in_wr), .in_funct3(in_funct3), .in_boff(in_boff),
        .in_rout(in_rout), .in_pc(in_pc), .in_imm(in_imm), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .rf_we(rf_we_s), .rf_waddr(rf_waddr_s), .rf_wdata(rf_wdata_s),
        .busy(busy_s), .load_err(load_err_s), .retire_cnt(retire_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (rf_we || load_err || rf_we_s || load_err_s)) begin
            exp_t e;
            if (sb.size() == 0) begin
                check("unexpected_write", {26'd0, rf_we, rf_waddr}, 32'd0);
            end else begin
                e = sb.pop_front();
                if (e.err)
                    check("err_pulse", {28'd0, rf_we, load_err, rf_we_s, load_err_s}, 32'h5);
                else begin
                    check("wr_addr", {22'd0, rf_we, rf_waddr, rf_we_s, rf_waddr_s},
                          {22'd0, 1'b1, e.addr, 1'b1, e.addr});
                    check("wr_data", rf_wdata, e.data);
                    check("wr_data_s", rf_wdata_s, e.data);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int n;
        exp_t e;
        in_sel    = v.sel;
        in_rd     = v.rd;
        in_wr     = v.wr;
        in_funct3 = v.f3;
        in_boff   = v.boff;
        in_rout   = (v.sel == 2'd0) ? v.a : 32'h1111_1111;
        in_pc     = (v.sel == 2'd1) ? v.a : 32'h2222_2222;
        in_imm    = (v.sel == 2'd2) ? v.a : 32'h3333_3333;
        in_valid  = 1'b1;
        n = 0;
        #1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_in_time", n, 0);
        e.err  = v.exp_err;
        e.addr = v.rd;
        e.data = v.exp_data;
        if (v.sel != 2'd3 && v.exp_we) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (v.sel == 2'd3) begin
            for (int w = 0; w < v.waitc; w++) begin
                @(negedge clk);
                check("ready_low_wait", {30'd0, in_ready, busy}, 32'h1);
                @(posedge clk); #1;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = v.mdata;
            if (v.exp_we || v.exp_err) sb.push_back(e);
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hA5A5_A5A5;
        end
        @(negedge clk);
        check("we_err_timing", {30'd0, rf_we, load_err}, {30'd0, v.exp_we, v.exp_err});
        if (v.exp_we) exp_cnt++;
        @(posedge clk); #1;
        check("idle_after", {30'd0, busy, busy_s}, 32'd0);
        check("retire_cnt", {16'd0, retire_cnt}, exp_cnt);
        check("retire_cnt_s", {30'd0, retire_cnt_s}, exp_cnt % 4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_outputs", {rf_we, load_err, busy, rf_waddr, rf_wdata},
              {3'b000, 5'd0, 32'd0});
        check("rst_cnt", {16'd0, retire_cnt}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{2'd0, 5'd5,  1'b1, 3'b000, 2'd0, 32'h0000_1234, 32'h0,          0, 1'b1, 1'b0, 32'h0000_1234};
        vecs[1]  = '{2'd1, 5'd7,  1'b1, 3'b000, 2'd0, 32'hFFFF_FFFC, 32'h0,          0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[2]  = '{2'd2, 5'd0,  1'b1, 3'b000, 2'd0, 32'h0000_0055, 32'h0,          0, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{2'd2, 5'd3,  1'b0, 3'b000, 2'd0, 32'h0000_0099, 32'h0,          0, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{2'd2, 5'd31, 1'b1, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'h0,          0, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[5]  = '{2'd3, 5'd8,  1'b1, 3'b000, 2'd2, 32'h0,         32'h0080_FF00, 3, 1'b1, 1'b0, 32'hFFFF_FF80};
        vecs[6]  = '{2'd3, 5'd9,  1'b1, 3'b101, 2'd2, 32'h0,         32'h0080_FF00, 1, 1'b1, 1'b0, 32'h0000_0080};
        vecs[7]  = '{2'd3, 5'd10, 1'b1, 3'b100, 2'd1, 32'h0,         32'h0080_FF00, 2, 1'b1, 1'b0, 32'h0000_00FF};
        vecs[8]  = '{2'd3, 5'd11, 1'b1, 3'b001, 2'd3, 32'h0,         32'h8001_1234, 0, 1'b1, 1'b0, 32'hFFFF_8001};
        vecs[9]  = '{2'd3, 5'd12, 1'b1, 3'b010, 2'd0, 32'h0,         32'hCAFE_F00D, 0, 1'b1, 1'b0, 32'hCAFE_F00D};
        vecs[10] = '{2'd3, 5'd13, 1'b1, 3'b000, 2'd0, 32'h0,         32'h0000_007F, 1, 1'b1, 1'b0, 32'h0000_007F};
        vecs[11] = '{2'd3, 5'd14, 1'b1, 3'b011, 2'd0, 32'h0,         32'h1234_5678, 1, 1'b0, 1'b1, 32'h0};
        vecs[12] = '{2'd3, 5'd15, 1'b1, 3'b110, 2'd1, 32'h0,         32'h1234_5678, 0, 1'b0, 1'b1, 32'h0};
        vecs[13] = '{2'd1, 5'd1,  1'b1, 3'b000, 2'd0, 32'h0000_0100, 32'h0,          0, 1'b1, 1'b0, 32'h0000_0104};

        reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_rd = 5'd0; in_wr = 1'b0;
        in_funct3 = 3'd0; in_boff = 2'd0; in_rout = 32'd0; in_pc = 32'd0; in_imm = 32'd0;
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        @(posedge clk); #1;
        do_reset();

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // Back-to-back ALU ops with in_valid held high.
        do_reset();
        in_valid = 1'b1; in_sel = 2'd0; in_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            in_rd   = 5'(i + 1);
            in_rout = 32'h100 + i;
            e.err = 1'b0; e.addr = in_rd; e.data = in_rout;
            sb.push_back(e);
            @(posedge clk); #1;
            @(negedge clk);
            check("b2b_we_ready", {30'd0, rf_we, in_ready}, 32'h3);
            exp_cnt++;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_idle", {31'd0, busy}, 32'd0);
        check("b2b_cnt", {16'd0, retire_cnt}, 32'd4);

        // enable low blocks accepts.
        enable = 1'b0; in_valid = 1'b1; in_rd = 5'd6; in_rout = 32'h66;
        #1;
        check("en0_ready", {30'd0, in_ready, in_ready_s}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("en0_no_accept", {31'd0, busy}, 32'd0);
        in_valid = 1'b0; enable = 1'b1;
        @(posedge clk); #1;

        // Reset in WAIT_MEM abandons the load; later mem_rvalid is ignored.
        in_valid = 1'b1; in_sel = 2'd3; in_funct3 = 3'b010; in_rd = 5'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("wm_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("wm_rst_busy", {30'd0, busy, rf_we}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; exp_cnt = 0;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("wm_no_write", {30'd0, rf_we, busy}, 32'd0);
        @(posedge clk); #1;

        // Counter wrap on the CNT_W=2 copy after five writes.
        for (int i = 0; i < 5; i++) run_vec(vecs[0]);
        check("wrap_s", {30'd0, retire_cnt_s}, 32'd1);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
